// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch for a 16-bit instruction set with optional 32-bit
// immediates. The block boots from a two-word reset vector, fetches
// instructions one word per cycle and assembles two-word instructions. It
// accepts redirects from execute (jump) and memory (RET/RTI), drops the
// current instruction on a decode flush, and takes an interrupt by reading a
// two-word interrupt vector. Results are presented in the IF/ID register.
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-low reset
//   imem_addr        out  instruction memory word address (combinational)
//   imem_data        in   instruction memory read data, same cycle
//   stall            in   hold PC, FSM and IF/ID
//   flush            in   inject a NOP into IF/ID, PC unchanged
//   jump_taken       in   redirect to jump_target
//   jump_target      in   branch/call target PC
//   pc_choose_memory in   redirect to mem_pc (highest priority)
//   mem_pc           in   PC popped by RET/RTI
//   int_load         in   start an interrupt vector fetch (RUN only)
//   int_ack          out  one-cycle pulse once the interrupt PC is loaded
//   ifid_instr       out  instruction word (first word of a two-word instr)
//   ifid_imm         out  immediate word, zero for one-word instructions
//   ifid_pc          out  address of the instruction's first word
//   ifid_pc_next     out  return address (word after the instruction)
//   ifid_valid       out  IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC   = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic        pc_choose_memory,
    input  logic [31:0] mem_pc,
    input  logic        int_load,
    output logic        int_ack,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_imm,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_next,
    output logic        ifid_valid
);

    typedef enum logic [2:0] {
        VEC_HI,
        VEC_LO,
        RUN,
        IMM,
        INT_HI,
        INT_LO
    } state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [15:0] hold;      // first word of a two-word instruction
    logic [31:0] hold_pc;   // address of that first word
    logic [15:0] vec_hi;    // high half of the vector being read (reset or interrupt)
    logic        two_word;

    assign pc_inc   = pc + 32'd1;
    assign two_word = (imem_data[15:13] == 3'b011);

    // Vector states read fixed addresses; everywhere else memory follows the PC.
    always_comb begin
        imem_addr = pc;
        unique case (state)
            VEC_HI:  imem_addr = RESET_VEC;
            VEC_LO:  imem_addr = RESET_VEC + 32'd1;
            INT_HI:  imem_addr = INT_VEC;
            INT_LO:  imem_addr = INT_VEC + 32'd1;
            default: imem_addr = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= VEC_HI;
            pc           <= RESET_VEC;
            hold         <= 16'h0000;
            hold_pc      <= 32'h0000_0000;
            vec_hi       <= 16'h0000;
            int_ack      <= 1'b0;
            ifid_instr   <= 16'h0000;
            ifid_imm     <= 16'h0000;
            ifid_pc      <= 32'h0000_0000;
            ifid_pc_next <= 32'h0000_0000;
            ifid_valid   <= 1'b0;
        end else begin
            int_ack <= 1'b0;
            unique case (state)
                // Boot sequence is not interruptible by any control input.
                VEC_HI: begin
                    vec_hi <= imem_data;
                    state  <= VEC_LO;
                end
                VEC_LO: begin
                    pc    <= {vec_hi, imem_data};
                    state <= RUN;
                end
                default: begin
                    if (pc_choose_memory || jump_taken) begin
                        // Memory-stage redirect is older than execute, so it wins.
                        pc         <= pc_choose_memory ? mem_pc : jump_target;
                        ifid_instr <= 16'h0000;
                        ifid_imm   <= 16'h0000;
                        ifid_valid <= 1'b0;
                        state      <= RUN;
                    end else if (flush) begin
                        // Returning to RUN drops any held first word or
                        // in-progress interrupt vector read.
                        ifid_instr <= 16'h0000;
                        ifid_imm   <= 16'h0000;
                        ifid_valid <= 1'b0;
                        state      <= RUN;
                    end else if (int_load && (state == RUN)) begin
                        ifid_instr <= 16'h0000;
                        ifid_imm   <= 16'h0000;
                        ifid_valid <= 1'b0;
                        state      <= INT_HI;
                    end else if (!stall) begin
                        unique case (state)
                            RUN: begin
                                pc <= pc_inc;
                                if (two_word) begin
                                    hold       <= imem_data;
                                    hold_pc    <= pc;
                                    ifid_valid <= 1'b0;
                                    state      <= IMM;
                                end else begin
                                    ifid_instr   <= imem_data;
                                    ifid_imm     <= 16'h0000;
                                    ifid_pc      <= pc;
                                    ifid_pc_next <= pc_inc;
                                    ifid_valid   <= 1'b1;
                                end
                            end
                            IMM: begin
                                ifid_instr   <= hold;
                                ifid_imm     <= imem_data;
                                ifid_pc      <= hold_pc;
                                ifid_pc_next <= pc_inc;
                                ifid_valid   <= 1'b1;
                                pc           <= pc_inc;
                                state        <= RUN;
                            end
                            INT_HI: begin
                                vec_hi <= imem_data;
                                state  <= INT_LO;
                            end
                            INT_LO: begin
                                pc      <= {vec_hi, imem_data};
                                int_ack <= 1'b1;
                                state   <= RUN;
                            end
                            default: begin
                                // Unused encodings recover through the boot path.
                                state <= VEC_HI;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed scenarios followed by randomized control traffic. Expected values
// come from a transaction-level model: boot/interrupt progress is tracked as
// remaining-word counters and two-word assembly as a pending flag.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] IV = 32'h0000_0002;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall, flush, jump_taken, pc_choose_memory, int_load;
    logic [31:0] jump_target, mem_pc;
    logic        int_ack;
    logic [15:0] ifid_instr, ifid_imm;
    logic [31:0] ifid_pc, ifid_pc_next;
    logic        ifid_valid;

    logic [15:0] mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage #(
        .RESET_VEC(RV),
        .INT_VEC  (IV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .stall            (stall),
        .flush            (flush),
        .jump_taken       (jump_taken),
        .jump_target      (jump_target),
        .pc_choose_memory (pc_choose_memory),
        .mem_pc           (mem_pc),
        .int_load         (int_load),
        .int_ack          (int_ack),
        .ifid_instr       (ifid_instr),
        .ifid_imm         (ifid_imm),
        .ifid_pc          (ifid_pc),
        .ifid_pc_next     (ifid_pc_next),
        .ifid_valid       (ifid_valid)
    );

    // Reference model state.
    int          boot_left = 0;   // vector words still to read after reset
    int          int_left  = 0;   // interrupt vector words still to read
    bit          pending   = 0;   // first word of a two-word instruction captured
    logic [31:0] m_pc = 0, m_hold_pc = 0, m_ipc = 0, m_ipcn = 0;
    logic [15:0] m_hold = 0, m_hi = 0, m_instr = 0, m_imm = 0;
    logic        m_valid = 0, m_ack = 0;

    function automatic logic [31:0] m_addr();
        if (boot_left == 2) return RV;
        if (boot_left == 1) return RV + 32'd1;
        if (int_left == 2)  return IV;
        if (int_left == 1)  return IV + 32'd1;
        return m_pc;
    endfunction

    task automatic m_clear();
        m_instr = 16'h0000;
        m_imm   = 16'h0000;
        m_valid = 1'b0;
        int_left = 0;
        pending  = 0;
    endtask

    task automatic model_edge(input bit r, input bit pcm, input logic [31:0] mp, input bit jt,
                              input logic [31:0] jtg, input bit fl, input bit il, input bit st);
        logic [31:0] a;
        logic [15:0] d;
        a = m_addr();
        d = mem[a[7:0]];
        m_ack = 1'b0;
        if (!r) begin
            boot_left = 2; int_left = 0; pending = 0;
            m_pc = RV; m_hold = 0; m_hold_pc = 0; m_hi = 0;
            m_instr = 0; m_imm = 0; m_ipc = 0; m_ipcn = 0; m_valid = 0;
        end else if (boot_left > 0) begin
            if (boot_left == 2) m_hi = d;
            else m_pc = {m_hi, d};
            boot_left--;
        end else if (pcm || jt) begin
            m_pc = pcm ? mp : jtg;
            m_clear();
        end else if (fl) begin
            m_clear();
        end else if (il && int_left == 0 && !pending) begin
            m_clear();
            int_left = 2;
        end else if (st) begin
            // everything frozen
        end else if (int_left == 2) begin
            m_hi = d;
            int_left = 1;
        end else if (int_left == 1) begin
            m_pc = {m_hi, d};
            int_left = 0;
            m_ack = 1'b1;
        end else if (pending) begin
            m_instr = m_hold; m_imm = d; m_ipc = m_hold_pc; m_ipcn = m_pc + 32'd1;
            m_valid = 1'b1; m_pc = m_pc + 32'd1; pending = 0;
        end else if (d[15:13] == 3'b011) begin
            m_hold = d; m_hold_pc = m_pc; m_valid = 1'b0; m_pc = m_pc + 32'd1; pending = 1;
        end else begin
            m_instr = d; m_imm = 0; m_ipc = m_pc; m_ipcn = m_pc + 32'd1;
            m_valid = 1'b1; m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit pcm, input logic [31:0] mp, input bit jt,
                        input logic [31:0] jtg, input bit fl, input bit il, input bit st);
        reset = r; pc_choose_memory = pcm; mem_pc = mp; jump_taken = jt;
        jump_target = jtg; flush = fl; int_load = il; stall = st;
        model_edge(r, pcm, mp, jt, jtg, fl, il, st);
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_addr());
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("int_ack", {31'd0, int_ack}, {31'd0, m_ack});
        chk("ifid_instr", {16'd0, ifid_instr}, {16'd0, m_instr});
        chk("ifid_imm", {16'd0, ifid_imm}, {16'd0, m_imm});
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_pc_next", ifid_pc_next, m_ipcn);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0000; mem[1] = 16'h0040;
        mem[2] = 16'h0000; mem[3] = 16'h0080;
        mem[8'h40] = 16'h1234;
        mem[8'h10] = 16'h6111;
        mem[8'h80] = 16'h1111;
        mem[8'hFF] = 16'h2222;

        // Reset state and boot from the reset vector.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        run(3);
        chk("boot_instr", {16'd0, ifid_instr}, 32'h1234);
        chk("boot_pc", ifid_pc, 32'h40);
        chk("boot_valid", {31'd0, ifid_valid}, 32'd1);

        // Two-word instruction after a fresh boot.
        mem[8'h40] = 16'h6001; mem[8'h41] = 16'hBEEF;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        run(3);
        chk("imm_bubble", {31'd0, ifid_valid}, 32'd0);
        run(1);
        chk("imm_instr", {16'd0, ifid_instr}, 32'h6001);
        chk("imm_imm", {16'd0, ifid_imm}, 32'hBEEF);
        chk("imm_pc", ifid_pc, 32'h40);
        chk("imm_pc_next", ifid_pc_next, 32'h42);

        // Jump beats flush and stall.
        step(1, 0, 0, 1, 32'h100, 1, 0, 1);
        chk("jmp_addr", imem_addr, 32'h100);
        chk("jmp_valid", {31'd0, ifid_valid}, 32'd0);

        // Memory redirect beats jump while in IMM; held word is dropped.
        step(1, 0, 0, 1, 32'h10, 0, 0, 0);
        run(1);
        step(1, 1, 32'h200, 1, 32'h300, 0, 0, 0);
        chk("ret_addr", imem_addr, 32'h200);
        run(1);
        chk("ret_pc", ifid_pc, 32'h200);
        chk("ret_instr", {16'd0, ifid_instr}, {16'd0, mem[0]});

        // Interrupt entry, then a fetch and a 3-cycle stall.
        step(1, 0, 0, 0, 0, 0, 1, 0);
        run(1);
        chk("int_wait_valid", {31'd0, ifid_valid}, 32'd0);
        run(1);
        chk("int_ack_pulse", {31'd0, int_ack}, 32'd1);
        chk("int_pc", imem_addr, 32'h80);
        run(1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 1);
            chk("stall_instr", {16'd0, ifid_instr}, 32'h1111);
            chk("stall_addr", imem_addr, 32'h81);
        end

        // PC wraps at 2^32.
        step(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        run(1);
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFF);
        chk("wrap_pc_next", ifid_pc_next, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of a two-word instruction.
        step(1, 0, 0, 1, 32'h10, 0, 0, 0);
        run(1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst_addr", imem_addr, RV);
        run(4);

        // Randomized control traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) != 0,
                 $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 14) == 0, $urandom,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000: imem word address holding the reset PC (high half), with the low half at RESET_VEC+1.
REQ-002 SHALL have parameter INT_VEC, default 32'h0000_0002: imem word address holding the interrupt PC (high half), with the low half at INT_VEC+1.
REQ-003 Port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, in, 1: synchronous, active-low reset.
REQ-005 Port imem_addr, out, 32: instruction memory word address, a combinational function of state and PC.
REQ-006 Port imem_data, in, 16: instruction memory read data, valid in the same cycle as imem_addr.
REQ-007 Port stall, in, 1: hold PC, FSM and IF/ID.
REQ-008 Port flush, in, 1: clear_instruction from decode; inject a NOP into IF/ID.
REQ-009 Port jump_taken, in, 1 and jump_target, in, 32: branch/call redirect from execute.
REQ-010 Port pc_choose_memory, in, 1 and mem_pc, in, 32: RET/RTI redirect with the PC popped in memory.
REQ-011 Port int_load, in, 1: load the interrupt vector; int_ack, out, 1: one-cycle pulse when the vector PC is loaded.
REQ-012 Port ifid_instr, out, 16; ifid_imm, out, 16; ifid_pc, out, 32 (address of the instruction's first word); ifid_pc_next, out, 32 (return address); ifid_valid, out, 1.

Function
REQ-013 SHALL implement FSM states VEC_HI, VEC_LO, RUN, IMM, INT_HI, INT_LO.
REQ-014 A two-word instruction SHALL be one whose first word has bits [15:13]==3'b011; its second word is the 16-bit immediate.
REQ-015 SHALL set imem_addr=PC in RUN and IMM, and in VEC_HI, VEC_LO, INT_HI and INT_LO imem_addr SHALL be the vector word being read.
REQ-016 Each cycle SHALL apply exactly one action, in priority order: pc_choose_memory, then jump_taken, then flush, then int_load (only accepted in RUN), then stall, then normal operation.
REQ-017 pc_choose_memory SHALL perform PC<=mem_pc, clear IF/ID (instr=16'h0000, imm=0, valid=0) and set state RUN, abandoning IMM; it SHALL be ignored in VEC_HI/VEC_LO.
REQ-018 jump_taken SHALL behave as REQ-017 but with PC<=jump_target.
REQ-019 flush SHALL clear IF/ID, leave PC unchanged and set state RUN; in IMM it SHALL also discard the held first word.
REQ-020 int_load in RUN SHALL clear IF/ID and go to INT_HI, and IF/ID SHALL stay invalid through INT_LO.
REQ-021 In INT_HI the block SHALL latch hi<=imem_data; in INT_LO it SHALL set PC<={hi,imem_data}, pulse int_ack=1 and go to RUN.
REQ-022 stall SHALL leave PC, state, the hold register and all IF/ID outputs unchanged.
REQ-023 In RUN with a one-word instruction: ifid_instr<=imem_data, ifid_imm<=0, ifid_pc<=PC, ifid_pc_next<=PC+1, ifid_valid<=1, PC<=PC+1.
REQ-024 In RUN with a two-word instruction: hold<=imem_data, hold_pc<=PC, ifid_valid<=0, PC<=PC+1, state IMM.
REQ-025 In IMM: ifid_instr<=hold, ifid_imm<=imem_data, ifid_pc<=hold_pc, ifid_pc_next<=PC+1, ifid_valid<=1, PC<=PC+1, state RUN.
REQ-026 PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFF+1 wraps to 0.
REQ-027 VEC_HI/VEC_LO SHALL ignore stall, flush and int_load, and jump_taken SHALL be ignored there as well.
REQ-028 int_ack SHALL be 0 in every cycle other than the INT_LO completion cycle.

Reset
REQ-029 When reset==0 at a clock edge: state<=VEC_HI, PC<=RESET_VEC, hold<=0, hold_pc<=0, IF/ID all zero, ifid_valid=0, int_ack=0, overriding all other inputs.
REQ-030 After reset release: VEC_HI SHALL latch the high half, VEC_LO SHALL load PC, and the first valid IF/ID SHALL appear 3 edges after release.
REQ-031 Reset asserted mid-IMM or mid-INT_* SHALL discard all in-flight state.

Verification
REQ-032 Reset with imem[0]=16'h0000, imem[1]=16'h0040, imem[0x40]=16'h1234 -> ifid_instr=16'h1234, ifid_pc=0x40, ifid_valid=1 on the 3rd edge after release.
REQ-033 imem[0x40]=16'h6001, imem[0x41]=16'hBEEF -> one bubble, then ifid_instr=16'h6001, ifid_imm=16'hBEEF, ifid_pc=0x40, ifid_pc_next=0x42, valid=1.
REQ-034 jump_taken=1, jump_target=0x100 on the same cycle as flush and stall -> PC=0x100 and IF/ID cleared, with jump winning.
REQ-035 pc_choose_memory=1 (mem_pc=0x200) together with jump_taken=1 (target 0x300) while in IMM -> PC=0x200, state RUN, held word discarded.
REQ-036 int_load in RUN with imem[2]=0, imem[3]=0x80 -> two invalid cycles, int_ack pulse, PC=0x80; stall for 3 cycles -> outputs frozen.
REQ-037 PC=32'hFFFF_FFFF with a one-word instruction -> ifid_pc_next=0, PC=0.
